// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS32 core: FETCH/DECODE/EXEC/MEM/WB sequencer over one shared req/ready memory port.
// Latency 3-5 cycles per instruction plus memory wait states; requests hold steady until mem_ready.
module multi_cycle_mips #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    state_t      state_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0] rf_q [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];

    alu_op_t alu_op;
    logic    use_imm, zext_imm, illegal;
    logic    is_beq, is_bne, is_j, is_jal, is_jr, is_lw, is_sw;

    always_comb begin
        alu_op   = ALU_ADD;
        use_imm  = 1'b0;
        zext_imm = 1'b0;
        illegal  = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        is_jr    = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00:        alu_op = ALU_SLL;
                    6'h02:        alu_op = ALU_SRL;
                    6'h03:        alu_op = ALU_SRA;
                    6'h08:        is_jr  = 1'b1;
                    6'h20, 6'h21: alu_op = ALU_ADD;
                    6'h22, 6'h23: alu_op = ALU_SUB;
                    6'h24:        alu_op = ALU_AND;
                    6'h25:        alu_op = ALU_OR;
                    6'h26:        alu_op = ALU_XOR;
                    6'h27:        alu_op = ALU_NOR;
                    6'h2a:        alu_op = ALU_SLT;
                    6'h2b:        alu_op = ALU_SLTU;
                    default:      illegal = 1'b1;
                endcase
            end
            6'h02: is_j   = 1'b1;
            6'h03: is_jal = 1'b1;
            6'h04: is_beq = 1'b1;
            6'h05: is_bne = 1'b1;
            6'h08, 6'h09: use_imm = 1'b1;
            6'h0a: begin use_imm = 1'b1; alu_op = ALU_SLT;  end
            6'h0b: begin use_imm = 1'b1; alu_op = ALU_SLTU; end
            6'h0c: begin use_imm = 1'b1; zext_imm = 1'b1; alu_op = ALU_AND; end
            6'h0d: begin use_imm = 1'b1; zext_imm = 1'b1; alu_op = ALU_OR;  end
            6'h0e: begin use_imm = 1'b1; zext_imm = 1'b1; alu_op = ALU_XOR; end
            6'h0f: alu_op = ALU_LUI;
            6'h23: begin use_imm = 1'b1; is_lw = 1'b1; end
            6'h2b: begin use_imm = 1'b1; is_sw = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

    logic [31:0] imm_ext, op_b, alu_res;

    assign imm_ext = zext_imm ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    assign op_b    = use_imm ? imm_ext : b_q;

    always_comb begin
        alu_res = 32'h0;
        case (alu_op)
            ALU_ADD:  alu_res = a_q + op_b;
            ALU_SUB:  alu_res = a_q - op_b;
            ALU_AND:  alu_res = a_q & op_b;
            ALU_OR:   alu_res = a_q | op_b;
            ALU_XOR:  alu_res = a_q ^ op_b;
            ALU_NOR:  alu_res = ~(a_q | op_b);
            ALU_SLT:  alu_res = {31'h0, $signed(a_q) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'h0, a_q < op_b};
            ALU_SLL:  alu_res = b_q << shamt;
            ALU_SRL:  alu_res = b_q >> shamt;
            ALU_SRA:  alu_res = $signed(b_q) >>> shamt;
            ALU_LUI:  alu_res = {imm, 16'h0000};
            default:  alu_res = 32'h0;
        endcase
    end

    // pc_q already holds PC+4 once the fetch has been accepted.
    logic [31:0] branch_target, jump_target;
    logic        branch_taken, ctrl_only;

    assign branch_target = pc_q + {{14{imm[15]}}, imm, 2'b00};
    assign jump_target   = {pc_q[31:28], ir_q[25:0], 2'b00};
    assign branch_taken  = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));
    assign ctrl_only     = is_beq || is_bne || is_j || is_jr;

    logic [31:0] rs_val, rt_val, wb_data;
    logic [4:0]  wb_dst;

    assign rs_val  = (rs == 5'd0) ? 32'h0 : rf_q[rs];
    assign rt_val  = (rt == 5'd0) ? 32'h0 : rf_q[rt];
    assign wb_dst  = is_jal ? 5'd31 : ((opcode == 6'h00) ? rd : rt);
    assign wb_data = is_lw ? mdr_q : alu_q;

    always_ff @(posedge clk) begin
        if (!reset && state_q == S_WB && wb_dst != 5'd0) begin
            rf_q[wb_dst] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            alu_q   <= 32'h0;
            mdr_q   <= 32'h0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= pc_q + 32'd4;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= rs_val;
                    b_q <= rt_val;
                    if (illegal) begin
                        state_q <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_q <= is_jal ? pc_q : alu_res;
                    if (branch_taken) begin
                        pc_q <= branch_target;
                    end else if (is_j || is_jal) begin
                        pc_q <= jump_target;
                    end else if (is_jr) begin
                        pc_q <= a_q;
                    end
                    if (ctrl_only) begin
                        state_q <= S_FETCH;
                    end else if (is_lw || is_sw) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mdr_q   <= mem_rdata;
                        state_q <= is_lw ? S_WB : S_FETCH;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Memory outputs are pure functions of registered state, so they hold steady across waits.
    assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign mem_we    = (state_q == S_MEM) && is_sw;
    assign mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign trap      = (state_q == S_TRAP);
    assign retire    = (state_q == S_WB)
                    || (state_q == S_EXEC && ctrl_only)
                    || (state_q == S_MEM && is_sw && mem_ready)
                    || (state_q == S_DECODE && illegal && !TRAP_ON_ILLEGAL);

endmodule

// File: doc/multi_cycle_mips.md
# multi_cycle_mips

Multi-cycle MIPS32 core that replaces the single-cycle datapath with an FSM-sequenced datapath sharing one memory port for instructions and data. It adds a ready/req memory handshake with arbitrary wait states, a parametrised reset vector, shifts, jumps and an illegal-opcode trap. It sits between the system testbench and a single unified memory model. The ALU and the 32x32 register file are internal.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TRAP_ON_ILLEGAL, 1: 1 = unknown opcode/funct halts in TRAP; 0 = treated as NOP.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- mem_req  out  1  memory request; held until accepted.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr  out  32  word-aligned byte address, valid with mem_req.
- mem_wdata  out  32  store data, valid with mem_req & mem_we.
- mem_rdata  in  32  read data, sampled on the accepting edge.
- mem_ready  in  1  accept; the transaction completes on an edge where mem_req & mem_ready.
- pc  out  32  architectural PC (register named PC).
- retire  out  1  one-cycle pulse as each instruction completes.
- trap  out  1  high while in TRAP.

## Operation
- ISA: everything the single-cycle core supports, i.e. add(u), sub(u), and, or, xor, nor, slt, sltu, beq, bne, lw, sw, addi(u), slti, sltiu, andi, ori, xori, lui. New: sll, srl, sra (shamt), j, jal, jr.
- No overflow exceptions and no delay slots. Branch target = PC+4 + (sext(imm)<<2).
- j/jal target = {PC+4[31:28], idx, 2'b00}. jal writes PC+4 to $31.
- Immediates: sign-extended for arith, slt* and memory ops. Zero-extended for andi/ori/xori. lui = imm<<16.
- $0 always reads 0. Writes to $0 are discarded.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On accept, IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt]. Illegal encoding goes to TRAP (or FETCH with a retire pulse if TRAP_ON_ILLEGAL=0).
  - EXEC: ALUOut<=result.
    - beq/bne: PC updated if taken, retire, go to FETCH.
    - j/jr: PC<=target, retire, go to FETCH.
    - lw/sw: go to MEM.
    - Everything else, including jal: go to WB.
  - MEM: mem_req=1, mem_addr=ALUOut, mem_we=sw, mem_wdata=B.
    - sw: on accept, retire, go to FETCH.
    - lw: on accept, MDR<=mem_rdata, go to WB.
  - WB: write the register file (rd for R-type, rt for I-type, $31 for jal), retire, go to FETCH.
  - TRAP: terminal. mem_req=0, trap=1. Exits only on reset.
- mem_req, mem_addr, mem_we and mem_wdata stay stable while waiting. mem_req=0 in DECODE, EXEC, WB and TRAP.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, mem_req=1 with mem_addr=RESET_PC in the cycle after reset, mem_we=0, retire=0, trap=0. The register file is not cleared, except $0.
- Reset asserted mid-wait drops the pending transaction. A store that was not accepted must not happen.
- Latency with mem_ready tied high, in cycles: branch/j/jr 3; sw 4; ALU/shift/jal 4; lw 5. Each wait cycle adds 1 to FETCH or MEM.
- retire is asserted during the final state cycle. PC has its new value on the following edge.
- The register-file write happens on the WB edge. The next FETCH's DECODE sees the new value, so no hazards exist.
- The address LSBs are passed through unchecked. Misaligned accesses are outside the contract.

## Test plan
- Program: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sltu $4,$2,$1, with ready=1 -> $3=2, $4=0, and retire pulses on cycles 4, 8, 12, 16.
- sw $3,8($0) then lw $5,8($0), with mem_ready low for 2 cycles on every request -> mem[8]=2 and $5=2. Address, we and wdata must stay stable while ready is low.
- beq $1,$1,+2 taken, then bne $1,$1,+2 not taken -> PC=0x0C after the first, then PC+4. Each takes 3 cycles.
- jal 0x40 at PC=0x10, then jr $31 at 0x40 -> $31=0x14 and the final PC=0x14. sra of 0x8000_0000 by 4 -> 0xF800_0000.
- Opcode 6'b111111 with TRAP_ON_ILLEGAL=1 -> trap=1, mem_req stays 0 and there is no retire. Reset clears trap and PC=RESET_PC.
- Assert reset while a sw waits in MEM with ready=0 -> the memory location is unchanged and the next request is a fetch at RESET_PC.
